conv_stage_param: RTL and testbench

//  Parametrised stage-2 convolution engine. On data_done it streams a ROWSxCOLSxCHANS feature map

---
 rtl/conv_stage_param.sv | 239 +++++++++++++++++++++++
 tb/tb_conv_stage_param.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stage_param.sv
// Stage-2 convolution engine: buffers one ROWSxCOLSxCHANS feature map from the
// stage-1 BRAM, then computes a valid KxKxCHANS convolution per filter with a
// single MAC per cycle, emitting results on a valid/ready stream.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for data_done
// LOAD  | streaming BRAM words into the tensor buffer (N+1 cycles)
// MAC   | accumulating K*K*CHANS taps for the current output
// EMIT  | presenting the result, waiting for res_ready
// DONE  | one-cycle frame_done pulse
module conv_stage_param #(
    parameter int DATA_W = 17,
    parameter int COEF_W = 8,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int CHANS  = 3,
    parameter int K      = 3,
    parameter int NFILT  = 4,
    parameter int ACC_W  = 35,
    parameter int ADDR_W = 8,
    localparam int CS_W  = $clog2(NFILT*K*K*CHANS),
    localparam int IDX_W = $clog2(NFILT*(ROWS-K+1)*(COLS-K+1))
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_done,
    input  logic              relu_en,
    output logic              busy,
    output logic              enable_read,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] BRAM_input,
    output logic [CS_W-1:0]   coef_sel,
    input  logic [COEF_W-1:0] coef_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [IDX_W-1:0]  res_idx,
    output logic              frame_done
);

    localparam int N     = ROWS*COLS*CHANS;
    localparam int OROWS = ROWS-K+1;
    localparam int OCOLS = COLS-K+1;
    localparam int LC_W  = $clog2(N+1);
    localparam int CH_W  = (CHANS > 1) ? $clog2(CHANS) : 1;
    localparam int K_W   = (K > 1)     ? $clog2(K)     : 1;
    localparam int OR_W  = (OROWS > 1) ? $clog2(OROWS) : 1;
    localparam int OC_W  = (OCOLS > 1) ? $clog2(OCOLS) : 1;
    localparam int F_W   = (NFILT > 1) ? $clog2(NFILT) : 1;

    localparam logic [LC_W-1:0] LOAD_END = LC_W'(N);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANS-1);
    localparam logic [K_W-1:0]  K_LAST   = K_W'(K-1);
    localparam logic [OR_W-1:0] OR_LAST  = OR_W'(OROWS-1);
    localparam logic [OC_W-1:0] OC_LAST  = OC_W'(OCOLS-1);
    localparam logic [F_W-1:0]  F_LAST   = F_W'(NFILT-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [LC_W-1:0]  load_cnt;
    logic             wr_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic [CH_W-1:0]  ch_cnt;
    logic [K_W-1:0]   kc_cnt;
    logic [K_W-1:0]   kr_cnt;
    logic [OC_W-1:0]  col_cnt;
    logic [OR_W-1:0]  row_cnt;
    logic [F_W-1:0]   filt_cnt;
    logic [IDX_W-1:0] idx_cnt;
    logic             relu_lat;
    logic signed [ACC_W-1:0] acc;

    logic signed [DATA_W-1:0] tensor [N];

    logic                     load_last;
    logic                     first_tap;
    logic                     last_tap;
    logic                     last_res;
    logic [ADDR_W-1:0]        tap_addr;
    logic [CS_W-1:0]          coef_idx;
    logic signed [DATA_W-1:0] x_s;
    logic signed [COEF_W-1:0] coef_s;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]         res_clamped;

    assign load_last = (load_cnt == LOAD_END);
    assign first_tap = (ch_cnt == '0) && (kc_cnt == '0) && (kr_cnt == '0);
    assign last_tap  = (ch_cnt == CH_LAST) && (kc_cnt == K_LAST) && (kr_cnt == K_LAST);
    assign last_res  = (filt_cnt == F_LAST) && (row_cnt == OR_LAST) && (col_cnt == OC_LAST);

    // Tensor word and coefficient index for the current tap (ch fastest, then kc, then kr)
    assign tap_addr = ((ADDR_W'(row_cnt) + ADDR_W'(kr_cnt)) * ADDR_W'(COLS)
                       + ADDR_W'(col_cnt) + ADDR_W'(kc_cnt)) * ADDR_W'(CHANS)
                      + ADDR_W'(ch_cnt);
    assign coef_idx = ((CS_W'(filt_cnt) * CS_W'(K) + CS_W'(kr_cnt)) * CS_W'(K)
                       + CS_W'(kc_cnt)) * CS_W'(CHANS) + CS_W'(ch_cnt);

    // Both operands are sign-extended to ACC_W so the product is exact at full width
    assign x_s      = tensor[tap_addr];
    assign coef_s   = coef_data;
    assign prod_ext = ACC_W'(x_s) * ACC_W'(coef_s);

    assign res_clamped = (relu_lat && acc[ACC_W-1]) ? '0 : acc;

    assign read_addr  = enable_read ? ADDR_W'(load_cnt) : '0;
    assign coef_sel   = (state == S_MAC)  ? coef_idx    : '0;
    assign res_data   = (state == S_EMIT) ? res_clamped : '0;
    assign res_idx    = (state == S_EMIT) ? idx_cnt     : '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs; res_valid depends on state only
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        enable_read = 1'b0;
        res_valid   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (data_done) state_next = S_LOAD;
            end
            S_LOAD: begin
                busy        = 1'b1;
                enable_read = !load_last;
                if (load_last) state_next = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (last_tap) state_next = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_next = last_res ? S_DONE : S_MAC;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counters, accumulator and the one-cycle-delayed buffer write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt <= '0;
            wr_pend  <= 1'b0;
            wr_addr  <= '0;
            ch_cnt   <= '0;
            kc_cnt   <= '0;
            kr_cnt   <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            filt_cnt <= '0;
            idx_cnt  <= '0;
            relu_lat <= 1'b0;
            acc      <= '0;
        end else begin
            wr_pend <= enable_read;
            wr_addr <= read_addr;
            case (state)
                S_IDLE: begin
                    if (data_done) begin
                        relu_lat <= relu_en;
                        load_cnt <= '0;
                        ch_cnt   <= '0;
                        kc_cnt   <= '0;
                        kr_cnt   <= '0;
                        col_cnt  <= '0;
                        row_cnt  <= '0;
                        filt_cnt <= '0;
                        idx_cnt  <= '0;
                        acc      <= '0;
                    end
                end
                S_LOAD: begin
                    if (!load_last) load_cnt <= load_cnt + LC_W'(1);
                end
                S_MAC: begin
                    acc <= (first_tap ? '0 : acc) + prod_ext;
                    if (ch_cnt == CH_LAST) begin
                        ch_cnt <= '0;
                        if (kc_cnt == K_LAST) begin
                            kc_cnt <= '0;
                            if (kr_cnt == K_LAST) kr_cnt <= '0;
                            else                  kr_cnt <= kr_cnt + K_W'(1);
                        end else begin
                            kc_cnt <= kc_cnt + K_W'(1);
                        end
                    end else begin
                        ch_cnt <= ch_cnt + CH_W'(1);
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        idx_cnt <= last_res ? '0 : idx_cnt + IDX_W'(1);
                        if (col_cnt == OC_LAST) begin
                            col_cnt <= '0;
                            if (row_cnt == OR_LAST) begin
                                row_cnt <= '0;
                                if (filt_cnt == F_LAST) filt_cnt <= '0;
                                else                    filt_cnt <= filt_cnt + F_W'(1);
                            end else begin
                                row_cnt <= row_cnt + OR_W'(1);
                            end
                        end else begin
                            col_cnt <= col_cnt + OC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tensor buffer: BRAM word lands one cycle after its address; never cleared
    always_ff @(posedge clk) begin
        if (wr_pend) tensor[wr_addr] <= BRAM_input;
    end

endmodule

// File: tb/tb_conv_stage_param.sv
// Randomised bench for conv_stage_param: BRAM and coefficient ROM models,
// a loop-based convolution reference and a negedge stream monitor.
module tb_conv_stage_param;

    localparam int DATA_W = 17;
    localparam int COEF_W = 8;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int CHANS  = 3;
    localparam int K      = 3;
    localparam int NFILT  = 4;
    localparam int ACC_W  = 35;
    localparam int ADDR_W = 8;
    localparam int N      = ROWS*COLS*CHANS;
    localparam int OR     = ROWS-K+1;
    localparam int OC     = COLS-K+1;
    localparam int NRES   = NFILT*OR*OC;
    localparam int NCOEF  = NFILT*K*K*CHANS;
    localparam int CS_W   = $clog2(NCOEF);
    localparam int IDX_W  = $clog2(NRES);
    localparam int LAT    = 193 + 144*(27+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              data_done;
    logic              relu_en;
    logic              busy;
    logic              enable_read;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] BRAM_input;
    logic [CS_W-1:0]   coef_sel;
    logic [COEF_W-1:0] coef_data;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [IDX_W-1:0]  res_idx;
    logic              frame_done;

    conv_stage_param dut (
        .clk        (clk),
        .reset      (reset),
        .data_done  (data_done),
        .relu_en    (relu_en),
        .busy       (busy),
        .enable_read(enable_read),
        .read_addr  (read_addr),
        .BRAM_input (BRAM_input),
        .coef_sel   (coef_sel),
        .coef_data  (coef_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic signed [DATA_W-1:0] mem  [N];
    logic signed [COEF_W-1:0] coef [NCOEF];
    longint gold [NRES];

    int n_checks = 0;
    int n_errs   = 0;

    int     cyc = 0;
    int     start_cyc;
    int     last_hs_cyc;
    int     rd_count;
    int     fd_count;
    int     valid_seen;
    bit     stall_en;
    bit     stalled;
    longint held_d;
    longint held_i;
    longint got_data[$];
    longint got_idx[$];

    // Synchronous BRAM model and combinational coefficient ROM
    always @(posedge clk) if (enable_read) BRAM_input <= mem[read_addr];
    assign coef_data = coef[coef_sel];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Consumer: always ready, or a fair coin each cycle
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            res_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor: read address order, stall stability, accepted results
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", $signed(res_data), held_d);
                check("hold_idx", res_idx, held_i);
            end
            if (res_valid && !res_ready) begin
                stalled = 1'b1;
                held_d  = $signed(res_data);
                held_i  = res_idx;
            end else begin
                stalled = 1'b0;
            end
            if (res_valid) valid_seen++;
            if (res_valid && res_ready) begin
                got_data.push_back($signed(res_data));
                got_idx.push_back(res_idx);
                last_hs_cyc = cyc;
            end
            if (frame_done) fd_count++;
            if (enable_read) begin
                check("read_addr", read_addr, rd_count);
                rd_count++;
            end
        end
    end

    // Reference: direct valid convolution over the stored map and coefficients
    task automatic build_gold(input bit relu);
        for (int f = 0; f < NFILT; f++)
            for (int r = 0; r < OR; r++)
                for (int c = 0; c < OC; c++) begin
                    longint s = 0;
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++)
                            for (int ch = 0; ch < CHANS; ch++)
                                s += longint'(mem[((r+kr)*COLS + c+kc)*CHANS + ch])
                                   * longint'(coef[((f*K+kr)*K + kc)*CHANS + ch]);
                    if (relu && s < 0) s = 0;
                    gold[(f*OR + r)*OC + c] = s;
                end
    endtask

    // mode 0: all ones, 1: ramp map + filter-2 centre tap, 2: 5 / -1, 3: random
    task automatic fill(input int mode);
        for (int a = 0; a < N; a++) begin
            case (mode)
                0:       mem[a] = 1;
                1:       mem[a] = DATA_W'(a / CHANS);
                2:       mem[a] = 5;
                default: mem[a] = DATA_W'($urandom);
            endcase
        end
        for (int i = 0; i < NCOEF; i++) begin
            case (mode)
                0:       coef[i] = 1;
                1:       coef[i] = (i / (K*K*CHANS) == 2 && (i % (K*K*CHANS)) / CHANS == 4) ? 8'sd1 : 8'sd0;
                2:       coef[i] = -1;
                default: coef[i] = COEF_W'($urandom);
            endcase
        end
    endtask

    task automatic clear_obs();
        got_data.delete();
        got_idx.delete();
        rd_count   = 0;
        fd_count   = 0;
        valid_seen = 0;
    endtask

    task automatic start_pulse(input bit relu);
        @(posedge clk);
        #1;
        relu_en   = relu;
        data_done = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        data_done = 1'b0;
        relu_en   = ~relu;
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 data_done = 1'b1;
        @(posedge clk);
        #1 data_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_enable_read"}, enable_read, 0);
        check({tag, "_read_addr"}, read_addr, 0);
        check({tag, "_coef_sel"}, coef_sel, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_idx"}, res_idx, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic run_frame(input bit relu, input bit stall, input bit dbl, input bit chk_lat);
        int cycles;
        stall_en = stall;
        build_gold(relu);
        clear_obs();
        start_pulse(relu);
        check("busy_after_start", busy, 1);
        if (dbl) begin
            repeat (10) @(posedge clk);
            pulse_done();
            repeat (300) @(posedge clk);
            pulse_done();
        end
        cycles = 0;
        while (fd_count == 0 && cycles < 20000) begin
            @(posedge clk);
            cycles++;
        end
        repeat (50) @(posedge clk);
        #1;
        check("frame_done_count", fd_count, 1);
        check("busy_after_frame", busy, 0);
        check("read_count", rd_count, N);
        check("result_count", got_idx.size(), NRES);
        for (int i = 0; i < got_idx.size() && i < NRES; i++) begin
            check("res_idx_order", got_idx[i], i);
            check("res_data", got_data[i], gold[i]);
        end
        if (chk_lat) check("last_handshake_latency", last_hs_cyc - start_cyc, LAT);
        stall_en = 1'b0;
    endtask

    initial begin
        int cycles;
        reset     = 1'b1;
        data_done = 1'b0;
        relu_en   = 1'b0;
        stall_en  = 1'b0;
        stalled   = 1'b0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // All ones: every result is K*K*CHANS
        fill(0);
        run_frame(0, 0, 0, 1);
        check("ones_first", got_data[0], 27);
        check("ones_last", got_data[NRES-1], 27);

        // Ramp map, filter 2 centre tap only
        fill(1);
        run_frame(0, 0, 0, 1);
        check("ramp_f2_r0c0", got_data[2*OR*OC + 0], 3*(1*8 + 1));
        check("ramp_f2_r5c5", got_data[2*OR*OC + 5*OC + 5], 3*(6*8 + 6));
        check("ramp_f2_r2c4", got_data[2*OR*OC + 2*OC + 4], 3*(3*8 + 5));
        check("ramp_f0_zero", got_data[7], 0);

        // Negative results with and without ReLU
        fill(2);
        run_frame(0, 0, 0, 1);
        check("neg_norelu", got_data[0], -135);
        check("neg_norelu_mid", got_data[77], -135);
        run_frame(1, 0, 0, 1);
        check("neg_relu", got_data[0], 0);

        // Random data under back-pressure
        fill(3);
        run_frame(0, 1, 0, 0);
        fill(3);
        run_frame(1, 1, 0, 0);

        // Extra starts during LOAD and MAC are ignored
        fill(3);
        run_frame(0, 0, 1, 1);

        // Abort mid-MAC of result 40, then a clean frame
        fill(3);
        build_gold(0);
        clear_obs();
        start_pulse(0);
        cycles = 0;
        while (got_idx.size() < 40 && cycles < 5000) begin
            @(posedge clk);
            cycles++;
        end
        check("reach_result_40", got_idx.size(), 40);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");
        reset = 1'b0;
        clear_obs();
        repeat (300) @(posedge clk);
        #1;
        check("no_valid_after_abort", valid_seen, 0);
        check("no_done_after_abort", fd_count, 0);
        fill(3);
        run_frame(0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
